// File: rtl/cache_pkg.sv
// Shared definitions for the cache replacement logic.
//   repl_mode_e  : run-time replacement policy select (tree PLRU / LFSR random)
//   repl_state_e : control FSM states of the replacement unit
//   LFSR_SEED    : value loaded into the random-mode LFSR on reset
//   LFSR_TAPS    : Galois toggle mask for x^16+x^14+x^13+x^11+1 (right shift)
//   lfsr_step()  : one LFSR advance
package cache_pkg;

  typedef enum logic {
    REPL_PLRU   = 1'b0,
    REPL_RANDOM = 1'b1
  } repl_mode_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } repl_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois form: the bit shifted out decides whether the
  // tap mask is folded back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helper for one cache set.
//   lkp_bits_i : tree bits of the set being looked up
//   victim_o   : way reached by walking the tree from the root
//   acc_bits_i : tree bits of the set being touched
//   acc_way_i  : way that was hit or filled
//   upd_bits_o : acc_bits_i with the touched way's root-to-leaf path pointing away
// Node 0 is the root, children of node n are 2n+1 / 2n+2; a node bit of 0
// steers the victim into the lower-index half.
module plru_tree #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  lkp_bits_i,
  output logic [WAY_W-1:0] victim_o,
  input  logic [WAYS-2:0]  acc_bits_i,
  input  logic [WAY_W-1:0] acc_way_i,
  output logic [WAYS-2:0]  upd_bits_o
);

  // Victim walk: each level contributes one victim bit, MSB first.
  always_comb begin : walk
    int   node;
    logic b;
    node     = 0;
    b        = 1'b0;
    victim_o = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == node) b = lkp_bits_i[n];
      end
      victim_o = (victim_o << 1) | WAY_W'(b);
      node     = 2*node + 1 + int'(b);
    end
  end

  // Touch update: the way index bits, MSB first, select the path; each node
  // on it is set to point at the opposite half.
  always_comb begin : touch
    int               node;
    logic             b;
    logic [WAY_W-1:0] w;
    node       = 0;
    b          = 1'b0;
    w          = acc_way_i;
    upd_bits_o = acc_bits_i;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b = w[WAY_W-1];
      w = w << 1;
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == node) upd_bits_o[n] = ~b;
      end
      node = 2*node + 1 + int'(b);
    end
  end

endmodule

// File: rtl/cache_repl_plru.sv
// N-way tree pseudo-LRU replacement unit with an LFSR random mode.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   mode_i            : 0 = tree PLRU, 1 = LFSR random (sampled with lookup)
//   flush_i           : pulse, restarts the clearing sweep over all sets
//   ready_o           : lookups and accesses accepted when high
//   lookup_valid_i/lookup_set_i/way_valid_i : victim request
//   victim_valid_o/victim_way_o             : registered result, 1 cycle later
//   access_valid_i/access_set_i/access_way_i: hit or fill touch
// After reset (or a flush) the tree storage is zeroed one set per cycle;
// requests are ignored until the sweep is done.
module cache_repl_plru
  import cache_pkg::*;
#(
  parameter  int SETS  = 128,
  parameter  int WAYS  = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mode_i,
  input  logic             flush_i,
  output logic             ready_o,
  input  logic             lookup_valid_i,
  input  logic [IDX_W-1:0] lookup_set_i,
  input  logic [WAYS-1:0]  way_valid_i,
  output logic             victim_valid_o,
  output logic [WAY_W-1:0] victim_way_o,
  input  logic             access_valid_i,
  input  logic [IDX_W-1:0] access_set_i,
  input  logic [WAY_W-1:0] access_way_i
);

  repl_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             victim_valid_q, victim_valid_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;

  logic [WAYS-2:0]  tree_q [SETS];

  logic             clr_en;
  logic             lkp_fire;
  logic             acc_fire;
  logic [WAY_W-1:0] plru_way;
  logic [WAYS-2:0]  upd_bits;
  logic [WAY_W-1:0] inv_way;
  logic             inv_any;
  logic [WAY_W-1:0] sel_way;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == IDX_W'(SETS-1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_o = (state_q == ST_IDLE);
    clr_en  = (state_q == ST_INIT);
  end

  // A flush in the same cycle as a request takes precedence over it.
  assign lkp_fire = ready_o & lookup_valid_i & ~flush_i;
  assign acc_fire = ready_o & access_valid_i & ~flush_i;

  plru_tree #(.WAYS(WAYS)) u_tree (
    .lkp_bits_i (tree_q[lookup_set_i]),
    .victim_o   (plru_way),
    .acc_bits_i (tree_q[access_set_i]),
    .acc_way_i  (access_way_i),
    .upd_bits_o (upd_bits)
  );

  // Tree storage has no reset: the sweep zeroes it. The lookup path reads
  // the old contents, so a same-cycle access to the same set is not seen.
  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      tree_q[cnt_q] <= '0;
    end else if (acc_fire) begin
      tree_q[access_set_i] <= upd_bits;
    end
  end

  // Invalid ways always win; scanning downwards leaves the lowest one.
  always_comb begin
    inv_any = ~&way_valid_i;
    inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!way_valid_i[w]) inv_way = WAY_W'(w);
    end
    if (inv_any) begin
      sel_way = inv_way;
    end else if (repl_mode_e'(mode_i) == REPL_RANDOM) begin
      sel_way = lfsr_q[WAY_W-1:0];
    end else begin
      sel_way = plru_way;
    end
  end

  assign lfsr_d         = lfsr_step(lfsr_q);
  assign victim_valid_d = lkp_fire;
  assign victim_way_d   = lkp_fire ? sel_way : victim_way_q;

  // Result register and free-running LFSR
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q         <= LFSR_SEED;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      lfsr_q         <= lfsr_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  assign victim_valid_o = victim_valid_q;
  assign victim_way_o   = victim_way_q;

endmodule

// File: tb/tb_cache_repl_plru.sv
module tb_cache_repl_plru;

  localparam int SETS  = 128;
  localparam int WAYS  = 4;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             mode_i;
  logic             flush_i;
  logic             ready_o;
  logic             lookup_valid_i;
  logic [IDX_W-1:0] lookup_set_i;
  logic [WAYS-1:0]  way_valid_i;
  logic             victim_valid_o;
  logic [WAY_W-1:0] victim_way_o;
  logic             access_valid_i;
  logic [IDX_W-1:0] access_set_i;
  logic [WAY_W-1:0] access_way_i;

  cache_repl_plru #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mode_i         (mode_i),
    .flush_i        (flush_i),
    .ready_o        (ready_o),
    .lookup_valid_i (lookup_valid_i),
    .lookup_set_i   (lookup_set_i),
    .way_valid_i    (way_valid_i),
    .victim_valid_o (victim_valid_o),
    .victim_way_o   (victim_way_o),
    .access_valid_i (access_valid_i),
    .access_set_i   (access_set_i),
    .access_way_i   (access_way_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per set/way the time of the last touch (0 = never).
  // Tree PLRU steers, at every level, away from the half holding the most
  // recent touch; an untouched subtree steers left.
  longint unsigned  ts [SETS][WAYS];
  longint unsigned  now;
  bit               m_ready;
  logic [WAY_W-1:0] m_vway;
  logic [15:0]      m_lfsr;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois: bits 15,13,12,10 toggle.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) m_lfsr <= 16'hACE1;
    else begin
      logic [15:0] n;
      n = {1'b0, m_lfsr[15:1]};
      if (m_lfsr[0]) begin
        n[15] = ~n[15]; n[13] = ~n[13]; n[12] = ~n[12]; n[10] = ~n[10];
      end
      m_lfsr <= n;
    end
  end

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) ts[s][w] = 0;
  endfunction

  function automatic logic [WAY_W-1:0] model_plru(int set);
    int lo = 0;
    int size = WAYS;
    while (size > 1) begin
      longint unsigned ml = 0, mr = 0;
      int half = size / 2;
      for (int i = 0; i < half; i++) begin
        if (ts[set][lo+i] > ml) ml = ts[set][lo+i];
        if (ts[set][lo+half+i] > mr) mr = ts[set][lo+half+i];
      end
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return WAY_W'(lo);
  endfunction

  function automatic logic [WAY_W-1:0] model_victim(int set, logic [WAYS-1:0] vld, logic md);
    for (int w = 0; w < WAYS; w++)
      if (!vld[w]) return WAY_W'(w);
    if (md) return m_lfsr[WAY_W-1:0];
    return model_plru(set);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycle();
    lookup_valid_i = 1'b0;
    access_valid_i = 1'b0;
    flush_i        = 1'b0;
    step();
  endtask

  // Drives one cycle of requests, advances the model, and returns what the
  // result register must show after the edge.
  task automatic do_cycle(input logic lv, input int ls, input logic [WAYS-1:0] wv,
                          input logic md, input logic av, input int as, input int aw,
                          input logic fl, output logic exp_v, output logic [WAY_W-1:0] exp_w);
    bit fire;
    lookup_valid_i = lv;
    lookup_set_i   = IDX_W'(ls);
    way_valid_i    = wv;
    mode_i         = md;
    access_valid_i = av;
    access_set_i   = IDX_W'(as);
    access_way_i   = WAY_W'(aw);
    flush_i        = fl;
    fire  = m_ready && !fl;
    exp_v = lv && fire;
    if (exp_v) m_vway = model_victim(ls, wv, md);
    exp_w = m_vway;
    if (av && fire) begin
      now++;
      ts[as][aw] = now;
    end
    if (fl) begin
      model_clear();
      m_ready = 0;
    end
    step();
    lookup_valid_i = 1'b0;
    access_valid_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_ready = 0;
    m_vway  = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    mode_i = 1'b0; flush_i = 1'b0; lookup_valid_i = 1'b0; lookup_set_i = '0;
    way_valid_i = '1; access_valid_i = 1'b0; access_set_i = '0; access_way_i = '0;
    now = 0;
    model_reset();
    repeat (3) step();
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready_o); end
    n_checks++;
    if (victim_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid got %b want 0", victim_valid_o); end
    n_checks++;
    if (victim_way_o !== '0) begin n_fail++; $display("FAIL reset_vway got %0d want 0", victim_way_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_init_timing();
    logic ev; logic [WAY_W-1:0] ew;
    for (int k = 0; k < SETS; k++) begin
      n_checks++;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL init_ready cycle %0d got %b want 0", k, ready_o); end
      if (k == 50) begin
        do_cycle(1'b1, 10, '1, 1'b0, 1'b1, 10, 1, 1'b0, ev, ew);
        n_checks++;
        if (victim_valid_o !== ev) begin n_fail++; $display("FAIL init_lookup_ignored got %b want %b", victim_valid_o, ev); end
      end else begin
        idle_cycle();
      end
    end
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL init_done_ready got %b want 1", ready_o); end
    m_ready = 1;
  endtask

  task automatic test_invalid_priority();
    logic ev; logic [WAY_W-1:0] ew;
    logic [WAYS-1:0] pats [3] = '{4'b1011, 4'b0000, 4'b0111};
    logic [WAY_W-1:0] want [3] = '{2'd2, 2'd0, 2'd3};
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 9, pats[i], (i == 2), 1'b0, 0, 0, 1'b0, ev, ew);
      n_checks++;
      if (victim_valid_o !== 1'b1) begin n_fail++; $display("FAIL inv_vvalid %0d got %b want 1", i, victim_valid_o); end
      n_checks++;
      if (victim_way_o !== want[i]) begin n_fail++; $display("FAIL inv_way %b got %0d want %0d", pats[i], victim_way_o, want[i]); end
    end
    idle_cycle();
    n_checks++;
    if (victim_valid_o !== 1'b0) begin n_fail++; $display("FAIL strobe_one_cycle got %b want 0", victim_valid_o); end
    n_checks++;
    if (victim_way_o !== 2'd3) begin n_fail++; $display("FAIL way_hold got %0d want 3", victim_way_o); end
  endtask

  task automatic test_plru_sequence();
    // op: -1 = lookup (check against want), otherwise access to that way
    int               ops  [10] = '{-1, 0, -1, 0, 1, 2, 3, -1, 0, -1};
    logic [WAY_W-1:0] want [10] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    logic ev; logic [WAY_W-1:0] ew;
    for (int i = 0; i < 10; i++) begin
      if (ops[i] < 0) begin
        do_cycle(1'b1, 5, '1, 1'b0, 1'b0, 5, 0, 1'b0, ev, ew);
        n_checks++;
        if (victim_valid_o !== 1'b1 || victim_way_o !== want[i])
          begin n_fail++; $display("FAIL plru_seq step %0d got v=%b w=%0d want v=1 w=%0d", i, victim_valid_o, victim_way_o, want[i]); end
      end else begin
        do_cycle(1'b0, 5, '1, 1'b0, 1'b1, 5, ops[i], 1'b0, ev, ew);
      end
    end
  endtask

  task automatic test_back_to_back_hazard();
    logic ev; logic [WAY_W-1:0] ew;
    do_cycle(1'b1, 7, '1, 1'b0, 1'b1, 7, 0, 1'b0, ev, ew);
    n_checks++;
    if (victim_valid_o !== 1'b1 || victim_way_o !== 2'd0)
      begin n_fail++; $display("FAIL hazard_first got v=%b w=%0d want v=1 w=0", victim_valid_o, victim_way_o); end
    do_cycle(1'b1, 7, '1, 1'b0, 1'b0, 7, 0, 1'b0, ev, ew);
    n_checks++;
    if (victim_valid_o !== 1'b1 || victim_way_o !== 2'd2)
      begin n_fail++; $display("FAIL hazard_second got v=%b w=%0d want v=1 w=2", victim_valid_o, victim_way_o); end
  endtask

  task automatic wait_sweep(input string tag);
    for (int k = 0; k < SETS; k++) begin
      n_checks++;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL %s_ready cycle %0d got %b want 0", tag, k, ready_o); end
      idle_cycle();
    end
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL %s_done got %b want 1", tag, ready_o); end
    m_ready = 1;
  endtask

  task automatic test_flush();
    logic ev; logic [WAY_W-1:0] ew;
    do_cycle(1'b0, 3, '1, 1'b0, 1'b1, 3, 0, 1'b0, ev, ew);
    // flush together with an access: the access must be dropped
    do_cycle(1'b1, 3, '1, 1'b0, 1'b1, 3, 2, 1'b1, ev, ew);
    n_checks++;
    if (victim_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_wins got %b want 0", victim_valid_o); end
    wait_sweep("flush");
    do_cycle(1'b1, 3, '1, 1'b0, 1'b0, 3, 0, 1'b0, ev, ew);
    n_checks++;
    if (victim_valid_o !== 1'b1 || victim_way_o !== 2'd0)
      begin n_fail++; $display("FAIL flush_cleared got v=%b w=%0d want v=1 w=0", victim_valid_o, victim_way_o); end
  endtask

  task automatic test_reset_mid_sweep();
    logic ev; logic [WAY_W-1:0] ew;
    do_cycle(1'b0, 0, '1, 1'b0, 1'b0, 0, 0, 1'b1, ev, ew);
    repeat (60) idle_cycle();
    rst_i = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL midsweep_rst_ready got %b want 0", ready_o); end
    step(); step();
    rst_i = 1'b0;
    wait_sweep("midsweep");
  endtask

  task automatic test_reset_mid_lookup();
    logic ev; logic [WAY_W-1:0] ew;
    do_cycle(1'b1, 1, 4'b1101, 1'b0, 1'b0, 0, 0, 1'b0, ev, ew);
    n_checks++;
    if (victim_valid_o !== 1'b1 || victim_way_o !== 2'd1)
      begin n_fail++; $display("FAIL prereset_lookup got v=%b w=%0d want v=1 w=1", victim_valid_o, victim_way_o); end
    rst_i = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (victim_valid_o !== 1'b0 || victim_way_o !== '0)
      begin n_fail++; $display("FAIL reset_drops_strobe got v=%b w=%0d want v=0 w=0", victim_valid_o, victim_way_o); end
    step();
    rst_i = 1'b0;
    wait_sweep("relookup");
  endtask

  task automatic test_random_mode();
    logic ev; logic [WAY_W-1:0] ew;
    logic [WAYS-1:0] wv;
    for (int i = 0; i < 40; i++) begin
      wv = (i % 5 == 4) ? (WAYS'($urandom_range(0, 14))) : '1;
      do_cycle(1'b1, $urandom_range(0, SETS-1), wv, 1'b1, 1'b0, 0, 0, 1'b0, ev, ew);
      n_checks++;
      if (victim_valid_o !== ev || victim_way_o !== ew)
        begin n_fail++; $display("FAIL random_mode %0d vld=%b got v=%b w=%0d want v=%b w=%0d", i, wv, victim_valid_o, victim_way_o, ev, ew); end
    end
  endtask

  task automatic test_random_traffic();
    logic ev; logic [WAY_W-1:0] ew;
    logic lv, av, md;
    logic [WAYS-1:0] wv;
    for (int i = 0; i < 400; i++) begin
      lv = ($urandom_range(0, 3) != 0);
      av = ($urandom_range(0, 2) != 0);
      md = ($urandom_range(0, 4) == 0);
      wv = ($urandom_range(0, 7) == 0) ? WAYS'($urandom) : '1;
      do_cycle(lv, $urandom_range(0, 3), wv, md, av, $urandom_range(0, 3),
               $urandom_range(0, WAYS-1), 1'b0, ev, ew);
      n_checks++;
      if (victim_valid_o !== ev || victim_way_o !== ew)
        begin n_fail++; $display("FAIL traffic %0d got v=%b w=%0d want v=%b w=%0d", i, victim_valid_o, victim_way_o, ev, ew); end
    end
  endtask

  initial begin
    test_reset();
    test_init_timing();
    test_invalid_priority();
    test_plru_sequence();
    test_back_to_back_hazard();
    test_flush();
    test_reset_mid_sweep();
    test_reset_mid_lookup();
    test_random_mode();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_repl_plru.md
Name: cache_repl_plru

Overview:
- N-way tree pseudo-LRU replacement unit for the set-associative caches. It generalises the 2-way MRU bit to any power-of-two associativity.
- Keeps WAYS-1 tree bits per set and returns a registered victim way on lookup.
- Updates the tree bits on every hit or fill.
- Adds a run-time random mode, a sequential state-clear (init/flush) sweep, and a ready handshake.

Parameters:
- SETS, 128, number of sets; power of two, >= 2.
- WAYS, 4, associativity; power of two, 2..16.
- IDX_W, $clog2(SETS), set index width (derived, not overridden).
- WAY_W, $clog2(WAYS), way index width (derived, not overridden).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- mode_i  in  1  replacement mode: 0 = tree PLRU, 1 = LFSR random.
- flush_i  in  1  pulse; clears all tree state via the sweep.
- ready_o  out  1  high when lookups and accesses are accepted.
- lookup_valid_i  in  1  victim request.
- lookup_set_i  in  IDX_W  set of the victim request.
- way_valid_i  in  WAYS  valid bits of the looked-up set's ways.
- victim_valid_o  out  1  victim result strobe, one cycle after an accepted lookup.
- victim_way_o  out  WAY_W  chosen victim way.
- access_valid_i  in  1  hit or fill touch; updates the tree.
- access_set_i  in  IDX_W  set that was touched.
- access_way_i  in  WAY_W  way that was touched.

Behaviour:
- Storage: tree[SETS][WAYS-1].
  - Node 0 is the root; the children of node n are 2n+1 and 2n+2.
  - Leaf order maps to way 0..WAYS-1, left to right.
  - Node bit 0 means the victim lies in the left (lower-index) half; bit 1 means the right half.
- Reset (rst_i high, async):
  - FSM goes to INIT; sweep counter = 0.
  - ready_o = 0, victim_valid_o = 0, victim_way_o = 0.
  - LFSR = 16'hACE1.
  - The tree array is not reset directly; it is cleared by the sweep.
- FSM state INIT:
  - Each cycle writes zeros to tree[cnt] and increments cnt.
  - After the write of cnt = SETS-1, goes to IDLE.
  - SETS cycles after reset release, ready_o = 1.
- FSM state IDLE:
  - ready_o = 1.
  - flush_i = 1 goes to INIT with cnt = 0; ready_o drops the next cycle.
- Requests while ready_o = 0:
  - lookup_valid_i and access_valid_i are ignored: no state update, no victim strobe.
  - flush_i during INIT restarts the sweep at cnt = 0.
- Reset mid-sweep or mid-lookup: any pending victim strobe is dropped and the sweep restarts from set 0.
- Lookup, latency 1:
  - An accepted lookup at cycle t gives victim_valid_o = 1 at t+1 for exactly one cycle.
  - victim_way_o is held until the next result.
- Victim select, in priority order:
  - (1) If any way_valid_i bit is 0, pick the lowest-index invalid way (in both modes).
  - (2) Otherwise, if mode_i = 0, walk the tree from the root following the node bits.
  - (3) Otherwise, if mode_i = 1, use LFSR[WAY_W-1:0].
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle after reset, in all states.
- Access update:
  - For each node on the root-to-leaf path of access_way_i, set the bit to point away from that way: bit = 1 if the way is in the left subtree, else 0.
  - Bits off the path are unchanged.
  - Updates happen in both modes, so a switch back to PLRU mode is coherent.
- Simultaneous lookup and access to the same set: the lookup uses the pre-update tree (read-before-write); the update lands that cycle.
- Simultaneous flush_i and a request in IDLE: the request is ignored and the flush wins.
- mode_i is sampled with the lookup and may change on any cycle.

Decomposition:
- Shared package cache_pkg:
  - repl_mode_e {REPL_PLRU, REPL_RANDOM}.
  - LFSR_SEED = 16'hACE1.
  - LFSR_TAPS = 16'hB400.
- Sub-module plru_tree: purely combinational.
  - Takes the tree bits and returns the victim way.
  - Takes the tree bits plus an access way and returns the updated bits.
  - Instantiated once in cache_repl_plru.

Test Plan:
1. Init timing: SETS=128, deassert rst_i at cycle 0 -> ready_o = 0 for cycles 0..127 and = 1 at cycle 128; a lookup at cycle 50 gives no victim_valid_o.
2. Invalid priority: WAYS=4, way_valid_i=4'b1011, lookup -> victim_way_o=2 at t+1; 4'b0000 -> 0.
3. PLRU sequence on set 5, all ways valid, mode 0:
   - After init, lookup -> 0.
   - Access 0, then lookup -> 2.
   - Access 0,1,2,3, then lookup -> 0.
   - Access 0, then lookup -> 2.
4. Same-cycle hazard: lookup and access(way 0) to set 7 in the same cycle from a fresh tree -> victim 0; the next lookup -> 2.
5. Flush mid-traffic:
   - Prime set 3 with access 0; assert flush_i -> ready_o = 0 for 128 cycles.
   - Afterwards, lookup set 3 -> 0.
   - Assert rst_i at sweep cycle 60 -> the sweep restarts and takes a full 128 cycles.
6. Random mode: mode_i=1, all ways valid, back-to-back lookups from reset -> victim_way_o equals the low WAY_W bits of the reference LFSR model sequence at each sample cycle; way_valid_i with a 0 bit still overrides.
